// File: rtl/decoder_pkg.sv
// Shared types and helpers for the pulse decoder: FSM state encoding,
// a constant-foldable clog2, and the default hold/gap lengths.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int HOLD_DEF = 3;
  localparam int GAP_DEF  = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pulse_decoder_2x4_pulse_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// The count saturates at zero, so it only restarts on an explicit load.
module pulse_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pulse_decoder_2x4.sv
// Turns an encoded index (y, z) into a one-hot strobe held HOLD cycles,
// followed by GAP idle cycles. Define PULSE_DECODER_SKID_EN for a one-entry skid buffer.
//
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both 1; in_y/in_z are sampled only then. in_valid may drop at any time
// while in_ready is 0 without effect.
module pulse_decoder_2x4
  import decoder_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int HOLD  = HOLD_DEF,
  parameter int GAP   = GAP_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [clog2(N_OUT)-1:0] in_y,
  input  logic                    in_z,
  output logic [N_OUT-1:0]        w_out,
  output logic                    busy,
  output logic                    err
);

  localparam int IDX_W   = clog2(N_OUT);
  localparam int MAXV    = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W   = (clog2(MAXV) > 0) ? clog2(MAXV) : 1;
  localparam int HOLD_LD = HOLD - 1;
  localparam int GAP_LD  = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [N_OUT-1:0] ONE = 1;

  state_e             state, state_d;
  logic [N_OUT-1:0]   w_d;
  logic               err_d;
  logic               ld;
  logic [CNT_W-1:0]   ld_val;
  logic               done;
  logic               xfer;

  assign xfer = in_valid && in_ready;
  assign busy = (state != ST_IDLE);

`ifdef PULSE_DECODER_SKID_EN
  logic             buf_full;
  logic [IDX_W-1:0] buf_idx;
  logic             buf_set, buf_clr;

  assign in_ready = (state == ST_IDLE) || !buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_idx  <= '0;
    end else if (buf_set) begin
      buf_full <= 1'b1;
      buf_idx  <= in_y;
    end else if (buf_clr) begin
      buf_full <= 1'b0;
    end
  end
`else
  assign in_ready = (state == ST_IDLE);
`endif

  always_comb begin
    state_d = state;
    w_d     = w_out;
    err_d   = 1'b0;
    ld      = 1'b0;
    ld_val  = CNT_W'(HOLD_LD);
`ifdef PULSE_DECODER_SKID_EN
    buf_set = 1'b0;
    buf_clr = 1'b0;
    if (state != ST_IDLE && xfer) begin
      if (in_z) buf_set = 1'b1;
      else      err_d   = 1'b1;
    end
`endif
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          if (in_z) begin
            state_d = ST_DRIVE;
            w_d     = ONE << in_y;
            ld      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DRIVE, ST_GAP: begin
        if (done) begin
          w_d = '0;
          if (state == ST_DRIVE && GAP > 0) begin
            state_d = ST_GAP;
            ld      = 1'b1;
            ld_val  = CNT_W'(GAP_LD);
          end else begin
            state_d = ST_IDLE;
`ifdef PULSE_DECODER_SKID_EN
            // Chain straight into the next pulse: buffered request first,
            // otherwise one arriving exactly as this phase ends.
            if (buf_full) begin
              state_d = ST_DRIVE;
              w_d     = ONE << buf_idx;
              ld      = 1'b1;
              buf_clr = 1'b1;
            end else if (xfer && in_z) begin
              state_d = ST_DRIVE;
              w_d     = ONE << in_y;
              ld      = 1'b1;
              buf_set = 1'b0;
            end
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        w_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      w_out <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      w_out <= w_d;
      err   <= err_d;
    end
  end

  pulse_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ld),
    .value (ld_val),
    .done  (done)
  );

endmodule

// File: tb/tb_pulse_decoder_2x4.sv
// Directed bench for pulse_decoder_2x4: default instance (HOLD=3, GAP=1)
// plus a HOLD=1, GAP=0 instance; skid sequence under PULSE_DECODER_SKID_EN.
module tb_pulse_decoder_2x4;

  logic       clk, rst_n;
  logic       a_valid, a_ready, a_z, a_busy, a_err;
  logic [1:0] a_y;
  logic [3:0] a_w;
  logic       b_valid, b_ready, b_z, b_busy, b_err;
  logic [1:0] b_y;
  logic [3:0] b_w;

  int n_pass = 0;
  int n_total = 0;

  pulse_decoder_2x4 #(.N_OUT(4), .HOLD(3), .GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_y(a_y), .in_z(a_z), .w_out(a_w), .busy(a_busy), .err(a_err)
  );

  pulse_decoder_2x4 #(.N_OUT(4), .HOLD(1), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_y(b_y), .in_z(b_z), .w_out(b_w), .busy(b_busy), .err(b_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_a(input string tag, input logic [3:0] w, input logic bz,
                       input logic rdy, input logic er);
    chk({tag, ".w"}, 32'(a_w), 32'(w));
    chk({tag, ".busy"}, 32'(a_busy), 32'(bz));
    chk({tag, ".ready"}, 32'(a_ready), 32'(rdy));
    chk({tag, ".err"}, 32'(a_err), 32'(er));
  endtask

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_y = 0; a_z = 0;
    b_valid = 0; b_y = 0; b_z = 0;
    #1;
    chk_a("reset", 4'b0000, 0, 1, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // single pulse y=2
    a_valid = 1; a_y = 2'b10; a_z = 1;
    step();
    a_valid = 0; a_y = 2'b00;
    chk_a("p2_t1", 4'b0100, 1, `ifdef PULSE_DECODER_SKID_EN 1 `else 0 `endif, 0);
    step(); chk_a("p2_t2", 4'b0100, 1, `ifdef PULSE_DECODER_SKID_EN 1 `else 0 `endif, 0);
    a_valid = 1;  // dropped valid has no effect while not ready (default build)
    `ifdef PULSE_DECODER_SKID_EN a_valid = 0; `endif
    step(); chk(  "p2_t3.w", 32'(a_w), 32'h4);
    a_valid = 0;
    step(); chk_a("p2_t4", 4'b0000, 1, `ifdef PULSE_DECODER_SKID_EN 1 `else 0 `endif, 0);
    step(); chk_a("p2_t5", 4'b0000, 0, 1, 0);

    // accepted request with z=0
    a_valid = 1; a_y = 2'b11; a_z = 0;
    step();
    a_valid = 0; a_z = 1;
    chk_a("errz_t1", 4'b0000, 0, 1, 1);
    step();
    chk_a("errz_t2", 4'b0000, 0, 1, 0);

`ifndef PULSE_DECODER_SKID_EN
    // valid held high: accepts spaced HOLD+GAP+1 = 5 cycles
    a_valid = 1; a_z = 1;
    for (int k = 0; k < 4; k++) begin
      a_y = 2'(k);
      chk("b2b.ready_pre", 32'(a_ready), 32'h1);
      step();
      for (int h = 0; h < 3; h++) begin
        chk("b2b.w", 32'(a_w), 32'(4'b0001 << k));
        chk("b2b.ready", 32'(a_ready), 32'h0);
        step();
      end
      chk("b2b.gap_w", 32'(a_w), 32'h0);
      chk("b2b.gap_busy", 32'(a_busy), 32'h1);
      if (k < 3) step();
    end
    a_valid = 0;
    step();
    chk_a("b2b_end", 4'b0000, 0, 1, 0);
`else
    // skid: y=3 buffered during DRIVE of y=0
    a_valid = 1; a_y = 2'b00; a_z = 1;
    step();
    chk_a("skid_t1", 4'b0001, 1, 1, 0);
    a_y = 2'b11;
    step();
    a_valid = 0;
    chk_a("skid_t2", 4'b0001, 1, 0, 0);
    step(); chk_a("skid_t3", 4'b0001, 1, 0, 0);
    step(); chk_a("skid_t4", 4'b0000, 1, 0, 0);
    step(); chk_a("skid_t5", 4'b1000, 1, 1, 0);
    step(); chk(  "skid_t6.w", 32'(a_w), 32'h8);
    step(); chk(  "skid_t7.w", 32'(a_w), 32'h8);
    step(); chk_a("skid_t8", 4'b0000, 1, 1, 0);
    step(); chk_a("skid_t9", 4'b0000, 0, 1, 0);
`endif

    // asynchronous reset mid-DRIVE
    a_valid = 1; a_y = 2'b10; a_z = 1;
    step();
    a_valid = 0;
    chk("mid.w_before", 32'(a_w), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    chk_a("mid_reset", 4'b0000, 0, 1, 0);
    step();
    rst_n = 1'b1;
    step();

    // HOLD=1, GAP=0 instance
`ifndef PULSE_DECODER_SKID_EN
    b_valid = 1; b_y = 2'b01; b_z = 1;
    step();
    chk("h1.w1", 32'(b_w), 32'h2);
    chk("h1.ready1", 32'(b_ready), 32'h0);
    b_y = 2'b11;
    step();
    chk("h1.zero_w", 32'(b_w), 32'h0);
    chk("h1.zero_busy", 32'(b_busy), 32'h0);
    chk("h1.zero_ready", 32'(b_ready), 32'h1);
    step();
    b_valid = 0;
    chk("h1.w2", 32'(b_w), 32'h8);
    step();
    chk("h1.end_w", 32'(b_w), 32'h0);
`else
    b_valid = 1; b_y = 2'b01; b_z = 1;
    step();
    b_valid = 0;
    chk("h1.w1", 32'(b_w), 32'h2);
    step();
    chk("h1.end_w", 32'(b_w), 32'h0);
    chk("h1.end_busy", 32'(b_busy), 32'h0);
`endif
    chk("h1.err", 32'(b_err), 32'h0);

    // report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $fatal(1, "FAIL timeout: observed no finish, expected finish before 20000");
  end

endmodule
